// File: rtl/aes_req_sched.sv
// Round-robin scheduler that shares one fully pipelined AES-128 core between
// NREQ requesters. A job's requester ID travels in a tag pipeline alongside the
// core, so each result lands in a response FIFO with its ID. Responses leave
// in issue order. An in-flight credit bound keeps the FIFO from overflowing.
module aes_req_sched #(
    parameter int NREQ    = 2,
    parameter int LATENCY = 21,
    parameter int DEPTH   = 24,
    parameter int IDW     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*128-1:0]          req_state,
    input  logic [NREQ*128-1:0]          req_key,
    output logic [127:0]                 core_state,
    output logic [127:0]                 core_key,
    input  logic [127:0]                 core_out,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [127:0]                 rsp_data,
    output logic [IDW-1:0]               rsp_id,
    output logic [$clog2(DEPTH+1)-1:0]   inflight,
    output logic                         busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 128 + IDW;

    // ---------------------------------------------------------------
    // Credit and arbitration
    // ---------------------------------------------------------------
    logic [CW-1:0]   inflight_reg;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   ptr_next;
    logic            credit_ok;
    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] hi_req;
    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] grant_oh;
    logic [IDW-1:0]  grant_id;
    logic            issue;
    logic            pop;
    logic            push;
    logic [127:0]    sel_state;
    logic [127:0]    sel_key;

    assign credit_ok = (inflight_reg < CW'(DEPTH));

    // Requests at or above the pointer take priority. If none of them is
    // valid, the search wraps to the full request set. The lowest set bit
    // is then isolated to get the grant.
    assign hi_mask  = ~((NREQ'(1) << ptr_reg) - NREQ'(1));
    assign hi_req   = req_valid & hi_mask;
    assign pick     = (|hi_req) ? hi_req : req_valid;
    assign grant_oh = pick & (~pick + NREQ'(1));

    // During reset no requester may be told it was accepted.
    assign req_ready = (rst && credit_ok) ? grant_oh : '0;
    assign issue     = |(req_valid & req_ready);

    // Encode the granted requester and select its plaintext/key slices.
    // req_ready is zero when nothing issues, so the selection is zero too.
    always_comb begin
        grant_id  = '0;
        sel_state = '0;
        sel_key   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) begin
                grant_id = IDW'(i);
            end
            if (req_ready[i]) begin
                sel_state = sel_state | req_state[128*i +: 128];
                sel_key   = sel_key   | req_key[128*i +: 128];
            end
        end
    end

    // Next pointer: one past the granted requester, wrapping at NREQ.
    always_comb begin
        ptr_next = PW'((int'(grant_id) + 1) % NREQ);
    end

    // Round-robin pointer advances only when a job is actually issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= '0;
        end else if (issue) begin
            ptr_reg <= ptr_next;
        end
    end

    // Issue register feeding the shared core. Idle cycles drive zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_state <= '0;
            core_key   <= '0;
        end else begin
            core_state <= sel_state;
            core_key   <= sel_key;
        end
    end

    // ---------------------------------------------------------------
    // Tag pipeline: stage 0 loads together with the core inputs. Stage
    // LATENCY lines up with core_out.
    // ---------------------------------------------------------------
    logic [LATENCY:0] tag_vld_reg;
    logic [IDW-1:0]   tag_id_reg [LATENCY+1];

    // Shift valid/ID every cycle. The pipeline never stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld_reg <= '0;
            for (int s = 0; s <= LATENCY; s++) begin
                tag_id_reg[s] <= '0;
            end
        end else begin
            tag_vld_reg[0] <= issue;
            tag_id_reg[0]  <= grant_id;
            for (int s = 1; s <= LATENCY; s++) begin
                tag_vld_reg[s] <= tag_vld_reg[s-1];
                tag_id_reg[s]  <= tag_id_reg[s-1];
            end
        end
    end

    assign push = tag_vld_reg[LATENCY];

    // ---------------------------------------------------------------
    // Response FIFO
    // ---------------------------------------------------------------
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [EW-1:0] head;

    assign rsp_valid = (count_reg != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign head      = mem[rd_ptr_reg];
    assign rsp_data  = rsp_valid ? head[127:0] : '0;
    assign rsp_id    = rsp_valid ? head[EW-1:128] : '0;

    // Storage array. It has no reset because only entries below count are
    // ever presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {tag_id_reg[LATENCY], core_out};
        end
    end

    // Pointer and occupancy bookkeeping. Credit keeps a push from ever
    // meeting a full FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Jobs issued but not yet popped. This counter gates new issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_reg <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   inflight_reg <= inflight_reg + CW'(1);
                2'b01:   inflight_reg <= inflight_reg - CW'(1);
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    assign inflight = inflight_reg;
    assign busy     = (inflight_reg != '0);

endmodule
